// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default widths, parity encodings.
package uart_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PRESC_W = 6;

   // Parity-type encodings (PAR_TYP input), shared with the receiver.
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Parallel-load shift register: presents the data word LSB first, with bit index and last-bit flag.
module uart_tx_serializer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_i,
   input  logic [DATA_W-1:0]           data_i,
   input  logic                        shift_i,
   output logic                        bit_o,
   output logic                        next_bit_c,
   output logic [$clog2(DATA_W)-1:0]   idx_o,
   output logic                        last_c
);

   localparam int unsigned IDX_W = $clog2(DATA_W);

   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   // Load has priority; a shift drops the current LSB and advances the index.
   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      if (load_i) begin
         shift_d = data_i;
         idx_d   = '0;
      end else if (shift_i) begin
         shift_d = {1'b0, shift_q[DATA_W-1:1]};
         idx_d   = idx_q + IDX_W'(1);
      end
   end

   // Shift register and index state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

   assign bit_o      = shift_q[0];
   assign next_bit_c = shift_q[1];
   assign idx_o      = idx_q;
   assign last_c     = (idx_q == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity, one stop bit.
module uart_tx #(
   parameter int unsigned DATA_W  = uart_pkg::DATA_W,
   parameter int unsigned PRESC_W = uart_pkg::PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  P_DATA,
   input  logic               Data_Valid,
   input  logic               PAR_EN,
   input  logic               PAR_TYP,
   input  logic [PRESC_W-1:0] Prescale,
   output logic               TX_OUT,
   output logic               busy
);

   import uart_pkg::*;

   localparam int unsigned IDX_W = $clog2(DATA_W);

   tx_state_e          state_q, state_d;
   logic [PRESC_W-1:0] cnt_q, cnt_d;
   logic [PRESC_W-1:0] n_q, n_d;
   logic               par_en_q, par_en_d;
   logic               par_bit_q, par_bit_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;

   logic               ser_load, ser_shift;
   logic               ser_bit, ser_next, ser_last;
   logic [IDX_W-1:0]   ser_idx;
   logic               bit_done;

   uart_tx_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ser_load),
      .data_i     (P_DATA),
      .shift_i    (ser_shift),
      .bit_o      (ser_bit),
      .next_bit_c (ser_next),
      .idx_o      (ser_idx),
      .last_c     (ser_last)
   );

   // Final prescale cycle of the current bit period.
   assign bit_done = (cnt_q == (n_q - PRESC_W'(1)));

   // Next-state logic; TX_OUT/busy next values follow the state being entered so both come straight from flops.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      n_d       = n_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      tx_d      = 1'b1;
      busy_d    = 1'b1;
      ser_load  = 1'b0;
      ser_shift = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            cnt_d  = '0;
            if (Data_Valid) begin
               state_d   = START;
               ser_load  = 1'b1;
               n_d       = (Prescale == '0) ? PRESC_W'(1) : Prescale;
               par_en_d  = PAR_EN;
               par_bit_d = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
               tx_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end

         START: begin
            if (bit_done) begin
               cnt_d   = '0;
               state_d = DATA;
               tx_d    = ser_bit;
            end else begin
               cnt_d = cnt_q + PRESC_W'(1);
               tx_d  = 1'b0;
            end
         end

         DATA: begin
            if (bit_done) begin
               cnt_d = '0;
               if (ser_last) begin
                  if (par_en_q) begin
                     state_d = PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  // Index stops at the last bit; it never wraps while in DATA.
                  ser_shift = (ser_idx != IDX_W'(DATA_W - 1));
                  tx_d      = ser_next;
               end
            end else begin
               cnt_d = cnt_q + PRESC_W'(1);
               tx_d  = ser_bit;
            end
         end

         PARITY: begin
            if (bit_done) begin
               cnt_d   = '0;
               state_d = STOP;
               tx_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + PRESC_W'(1);
               tx_d  = par_bit_q;
            end
         end

         STOP: begin
            if (bit_done) begin
               cnt_d   = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + PRESC_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, latched configuration and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         n_q       <= PRESC_W'(1);
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         n_q       <= n_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that sits directly upstream of the UART receiver. Its TX_OUT drives the receiver's RX_IN.
- Accepts an 8-bit parallel word with a valid strobe and emits one UART frame: start bit, 8 data bits LSB first, an optional parity bit, and one stop bit.
- Each bit lasts Prescale clk cycles.
- Frame configuration uses the same PAR_EN / PAR_TYP / Prescale semantics as the receiver, so a TX→RX loopback works with identical settings.

Parameters:
- DATA_W, 8, number of data bits per frame.
- PRESC_W, 6, width of the Prescale input.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_W  word to transmit. Sampled only on acceptance.
- Data_Valid  input  1  request strobe. Accepted when high and busy is low.
- PAR_EN  input  1  1 inserts a parity bit between data and stop. Latched on acceptance.
- PAR_TYP  input  1  0: parity bit = XOR of data bits (even parity). 1: parity bit = inverted XOR (odd parity). Latched on acceptance.
- Prescale  input  PRESC_W  clk cycles per bit. Latched on acceptance. Value 0 is treated as 1.
- TX_OUT  output  1  serial line, registered. Idles high.
- busy  output  1  high from the cycle after acceptance until the frame ends, registered.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - TX_OUT=1, busy=0, FSM=IDLE, all counters 0.
  - Any partial frame is abandoned; the line returns to idle high.
- FSM states and transitions:
  - IDLE: TX_OUT=1, busy=0. If Data_Valid=1 at a rising edge, latch P_DATA, PAR_EN, PAR_TYP and Prescale, then go to START.
  - START: TX_OUT=0 for N cycles, where N = latched Prescale, or 1 if that value is 0. Then go to DATA with bit index 0.
  - DATA: TX_OUT=data[idx] for N cycles per bit, idx 0..7. After bit 7, go to PARITY if PAR_EN, else STOP.
  - PARITY: TX_OUT=parity bit for N cycles. Then go to STOP.
  - STOP: TX_OUT=1 for N cycles. Then go to IDLE.
- Latency: Data_Valid high at rising edge k → TX_OUT=0 and busy=1 from edge k+1.
- Frame length: 10·N cycles without parity, 11·N with parity. busy stays high for exactly that many cycles.
- Back-to-back frames: at least 1 IDLE cycle (TX_OUT=1, busy=0) separates frames. With Data_Valid held high, the next frame starts at the edge after that idle cycle.
- Data_Valid while busy=1 is ignored. There is no queuing; the upstream block must hold the word until it sees busy=0.
- Input changes mid-frame have no effect, since the configuration is latched. P_DATA changes after acceptance do not alter the frame.
- Counters:
  - Prescale counter runs 0..N-1 and wraps to 0 on each bit boundary.
  - The bit index is 3 bits and never wraps inside DATA.
- TX_OUT is glitch-free because it comes from a flop, never a combinational mux output.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - constants DATA_W=8 and PRESC_W=6;
  - parity-type encodings PAR_EVEN=0 and PAR_ODD=1. These are reused by the receiver.
- One sub-module, uart_tx_serializer:
  - loads the word and shifts out LSB first on a shift enable;
  - provides the bit index and a last-bit flag.
- The top-level holds the FSM, the prescale counter, the parity computation and the TX_OUT/busy registers.

Test Plan:
- Reset check: assert rst mid-frame (during DATA bit 3, Prescale=8) → TX_OUT=1 and busy=0 immediately, before the next edge. After release, no frame resumes.
- Frame without parity: P_DATA=8'h45, PAR_EN=0, Prescale=8 → TX_OUT sequence 0,1,0,1,0,0,0,1,0,1, each held 8 cycles. busy is high for exactly 80 cycles.
- Even parity: P_DATA=8'hFF, PAR_EN=1, PAR_TYP=0, Prescale=8 → after the 8 data ones, the parity bit is 0, then stop=1. busy lasts 88 cycles.
- Odd parity: P_DATA=8'hA8, PAR_EN=1, PAR_TYP=1, Prescale=16 → parity bit is 0, since XOR of A8 is 1, inverted. Each bit lasts 16 cycles and the frame lasts 176 cycles.
- Back-to-back and ignore:
  - Data_Valid held high with 8'h12 and then 8'h34, Prescale=4 → two frames separated by exactly 1 idle cycle.
  - A pulse with 8'hAA while busy is not transmitted.
- Loopback and edge cases: connect TX_OUT to the receiver's RX_IN with Prescale=8, in all three parity modes, for data 8'h00, 8'h5A and 8'hFF → receiver P_DATA matches and data_valid pulses once per frame. Prescale=0 and Prescale=1 each give 1-cycle bits.
